// File: rtl/seq_mult_pw.sv
// seq_mult_pw: sequential shift-add multiplier with optional two's-complement mode.
// One adder is reused over WIDTH iterations. The operands are converted to
// sign/magnitude at accept. The product is negated once, at the final iteration.
//
// State table:
//   IDLE | waiting for start; busy=0, done=0
//   RUN  | one shift-add iteration per clock, WIDTH clocks; busy=1
//   DONE | P just loaded; done=1 for exactly one cycle; start here re-accepts
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           request, sampled only when not busy
//   mode_signed     treat A, B, P as two's complement (only when SIGNED_EN=1)
//   A, B            multiplicand / multiplier, sampled with start
//   P               registered product, held until the next done
//   busy, done      handshake status
//   led             sticky result-valid flag, cleared only by reset
module seq_mult_pw #(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done,
  output logic               led
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   acc, addend, acc_sum;
  logic [WIDTH-1:0] mcand, mplier, mag_a, mag_b;
  logic [CW-1:0]   cnt;
  logic            sgn, mode_eff, last_iter, accept;

  // The most negative operand negates to itself. As an unsigned value, that
  // result is exactly its magnitude 2^(W-1).
  always_comb begin
    mode_eff  = mode_signed & SIGNED_EN;
    mag_a     = (mode_eff && A[WIDTH-1]) ? -A : A;
    mag_b     = (mode_eff && B[WIDTH-1]) ? -B : B;
    addend    = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    acc_sum   = acc + addend;
    last_iter = (cnt == CW'(WIDTH - 1));
    accept    = start && ((state == IDLE) || (state == DONE));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      P      <= '0;
      led    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        sgn    <= mode_eff & (A[WIDTH-1] ^ B[WIDTH-1]);
        mcand  <= mag_a;
        mplier <= mag_b;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc    <= acc_sum;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last_iter) begin
          P   <= sgn ? -acc_sum : acc_sum;
          led <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_pw.sv
// Directed bench for seq_mult_pw. It uses three instances:
// W=4 signed-capable, W=4 unsigned-only, and W=8 signed-capable.
module tb_seq_mult_pw;

  logic       clk = 1'b0, rst = 1'b1;
  logic       start = 1'b0, mode = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;

  logic [7:0]  p4, p4u;
  logic [15:0] p8;
  logic busy4, done4, led4, busy4u, done4u, led4u, busy8, done8, led8;

  int checks = 0;
  int errors = 0;

  seq_mult_pw #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
    .clk(clk), .rst(rst), .start(start), .mode_signed(mode), .A(a4), .B(b4),
    .P(p4), .busy(busy4), .done(done4), .led(led4));

  seq_mult_pw #(.WIDTH(4), .SIGNED_EN(1'b0)) dut4u (
    .clk(clk), .rst(rst), .start(start), .mode_signed(mode), .A(a4), .B(b4),
    .P(p4u), .busy(busy4u), .done(done4u), .led(led4u));

  seq_mult_pw #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode_signed(mode8), .A(a8), .B(b8),
    .P(p8), .busy(busy8), .done(done8), .led(led8));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single W=4 operation on both 4-bit instances. es is the expected
  // signed-capable result and eu the unsigned-only result.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic m,
                      input logic [7:0] es, input logic [7:0] eu);
    int n;
    n = 0;
    a4 = a; b4 = b; mode = m; start = 1'b1;
    tick();
    start = 1'b0; a4 = ~a; b4 = ~b; mode = ~m;
    check("busy_after_accept", busy4, 1);
    while (!done4 && n < 20) begin
      tick();
      n++;
    end
    check("latency4", n, 4);
    check("p4", p4, es);
    check("p4u", p4u, eu);
    check("done4u_aligned", done4u, 1);
    check("led4", led4, 1);
    tick();
    check("done_one_cycle", done4, 0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic m);
    int n, ia, ib;
    logic [15:0] e;
    ia = m ? int'($signed(a)) : int'(a);
    ib = m ? int'($signed(b)) : int'(b);
    e  = 16'(ia * ib);
    n  = 0;
    a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom_range(255)); b8 = 8'($urandom_range(255));
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    check("latency8", n, 8);
    check("p8", p8, e);
    tick();
  endtask

  initial begin
    logic [3:0] opa [3];
    logic [3:0] opb [3];
    logic [7:0] ope [3];
    logic [7:0] last_p;
    int ndone, since, stray;

    tick(); tick();
    rst = 1'b0;
    check("rst_p4", p4, 0);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_led4", led4, 0);
    check("rst_p8", p8, 0);

    run4(4'd13, 4'd11, 1'b0, 8'h8F, 8'h8F);
    run4(4'hD,  4'd5,  1'b1, 8'hF1, 8'h41);
    run4(4'h8,  4'h8,  1'b1, 8'h40, 8'h40);
    run4(4'h8,  4'd7,  1'b1, 8'hC8, 8'h38);
    run4(4'hF,  4'hF,  1'b0, 8'hE1, 8'hE1);

    // Back-to-back run with start held high and garbage operands during RUN.
    opa = '{4'd2, 4'd5, 4'd7};
    opb = '{4'd3, 4'd6, 4'd7};
    ope = '{8'd6, 8'd30, 8'd49};
    last_p = 8'hE1;
    ndone = 0;
    since = 0;
    mode = 1'b0; a4 = opa[0]; b4 = opb[0]; start = 1'b1;
    tick();
    for (int c = 0; c < 40 && ndone < 3; c++) begin
      if (done4) begin
        a4 = opa[ndone]; b4 = opb[ndone];
      end else begin
        a4 = 4'($urandom_range(15)); b4 = 4'($urandom_range(15));
      end
      tick();
      since++;
      if (done4) begin
        check("hs_interval", since, (ndone == 0) ? 4 : 5);
        check("hs_p", p4, ope[ndone]);
        last_p = ope[ndone];
        ndone++;
        since = 0;
      end else begin
        check("hs_hold", p4, last_p);
      end
    end
    check("hs_count", ndone, 3);
    start = 1'b0;
    tick();
    check("hs_idle", busy4, 0);

    // Reset at the second RUN edge aborts the operation.
    a4 = 4'd9; b4 = 4'd9; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_p4", p4, 0);
    check("abort_busy4", busy4, 0);
    check("abort_done4", done4, 0);
    check("abort_led4", led4, 0);
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done4) stray++;
    end
    check("abort_no_done", stray, 0);
    run4(4'd6, 4'd7, 1'b0, 8'd42, 8'd42);

    run8(8'd255, 8'd255, 1'b0);
    check("p8_ffx", p8, 16'hFE01);
    run8(8'h80, 8'h80, 1'b1);
    check("p8_neg128sq", p8, 16'h4000);
    for (int i = 0; i < 1000; i++)
      run8(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
    check("led8", led8, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
